// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and channel state encoding for the registered demux
package demux_pkg;

    localparam int NCH           = 4;
    localparam int SEL_W         = 2;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/demux_chan_reg.sv
// rtl/demux_chan_reg.sv - one-entry holding register with valid/ready handshake
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    ch_state_t        state_q;
    ch_state_t        state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= din;
            end
        end
    end

    // A load wins over a drain, so drain plus refill in one cycle stays FULL.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = CH_FULL;
        end else if (state_q == CH_FULL && ready) begin
            state_d = CH_EMPTY;
        end
    end

    always_comb begin
        valid = (state_q == CH_FULL);
        dout  = data_q;
    end

endmodule

// File: rtl/demux4_4bit_reg.sv
// rtl/demux4_4bit_reg.sv - registered 1-to-4 demux with per-channel holding registers
module demux4_4bit_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             acc;
    logic [NCH-1:0]   load;
    logic [WIDTH-1:0] dout [NCH];

    // Ready looks only at the addressed channel so a stall elsewhere never blocks.
    assign in_ready = rst_n & (~out_valid[s] | out_ready[s]);
    assign acc      = in_valid & in_ready;

    always_comb begin
        load    = '0;
        load[s] = acc;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .load (load[k]),
            .din  (in),
            .ready(out_ready[k]),
            .dout (dout[k]),
            .valid(out_valid[k])
        );
    end

    assign out0 = dout[0];
    assign out1 = dout[1];
    assign out2 = dout[2];
    assign out3 = dout[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (acc) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_demux4_4bit_reg.sv
// tb/tb_demux4_4bit_reg.sv - self-checking bench for demux4_4bit_reg
module tb_demux4_4bit_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in;
    logic [1:0] s;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] xfer_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_data [4];
    bit m_valid [4];
    int m_cnt;

    demux4_4bit_reg #(.WIDTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_ready();
        if (!rst_n) return 0;
        return (!m_valid[s] || out_ready[s[1:0]]) ? 1 : 0;
    endfunction

    function automatic int m_valid_vec();
        int v = 0;
        for (int k = 0; k < 4; k++) if (m_valid[k]) v |= (1 << k);
        return v;
    endfunction

    // Reference: a transfer happens when valid meets ready; the target slot is loaded,
    // any other full slot whose consumer is ready empties.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_data[k]  = 0;
                m_valid[k] = 0;
            end
            m_cnt = 0;
        end else begin
            bit acc_now;
            acc_now = in_valid && (m_ready() != 0);
            for (int k = 0; k < 4; k++) begin
                if (acc_now && int'(s) == k) begin
                    m_data[k]  = int'(in);
                    m_valid[k] = 1;
                end else if (m_valid[k] && out_ready[k]) begin
                    m_valid[k] = 0;
                end
            end
            if (acc_now) m_cnt = (m_cnt + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_valid", int'(out_valid), m_valid_vec());
            check("model_out0", int'(out0), m_data[0]);
            check("model_out1", int'(out1), m_data[1]);
            check("model_out2", int'(out2), m_data[2]);
            check("model_out3", int'(out3), m_data[3]);
            check("model_xfer_cnt", int'(xfer_cnt), m_cnt);
            check("model_in_ready", int'(in_ready), m_ready());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in = 4'hF; s = 2'd0; out_ready = 4'b0000;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_outs", int'({out3, out2, out1, out0}), 0);
        check("rst_cnt", int'(xfer_cnt), 0);

        rst_n = 1'b1; out_ready = 4'b1111; in = 4'hA; s = 2'd2; in_valid = 1'b1;
        cyc();
        check("route_out2", int'(out2), 'hA);
        check("route_valid_a", int'(out_valid), 'b0100);
        in = 4'h5; s = 2'd0;
        cyc();
        check("route_out0", int'(out0), 'h5);
        check("route_valid_b", int'(out_valid), 'b0001);
        check("route_cnt", int'(xfer_cnt), 2);
        check("route_out2_kept", int'(out2), 'hA);
        in_valid = 1'b0;
        cyc();

        out_ready = 4'b0000; in = 4'h3; s = 2'd1; in_valid = 1'b1;
        cyc();
        check("stall_first", int'(out1), 3);
        in = 4'h7;
        #1;
        check("stall_ready_low", int'(in_ready), 0);
        cyc();
        check("stall_hold", int'(out1), 3);
        check("stall_cnt", int'(xfer_cnt), 3);

        in = 4'h9; s = 2'd3;
        #1;
        check("indep_ready", int'(in_ready), 1);
        cyc();
        check("indep_out3", int'(out3), 9);
        check("indep_out1", int'(out1), 3);
        check("indep_valid", int'(out_valid), 'b1010);

        in = 4'h7; s = 2'd1;
        #1;
        check("refill_ready_low", int'(in_ready), 0);
        out_ready = 4'b0010;
        #1;
        check("refill_ready_high", int'(in_ready), 1);
        cyc();
        check("refill_out1", int'(out1), 7);
        check("refill_valid", int'(out_valid), 'b1010);
        check("refill_cnt", int'(xfer_cnt), 5);

        out_ready = 4'b1111;
        for (int i = 0; i < 250; i++) begin
            in = 4'($urandom);
            s  = 2'($urandom);
            cyc();
        end
        check("wrap_255", int'(xfer_cnt), 255);
        cyc();
        check("wrap_0", int'(xfer_cnt), 0);

        in_valid = 1'b0;
        cyc();
        out_ready = 4'b0000; in_valid = 1'b1; in = 4'hC; s = 2'd0;
        cyc();
        in = 4'hD; s = 2'd2;
        cyc();
        in_valid = 1'b0;
        check("mid_valid", int'(out_valid), 'b0101);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_outs", int'({out3, out2, out1, out0}), 0);
        check("mid_rst_cnt", int'(xfer_cnt), 0);
        rst_n = 1'b1; out_ready = 4'b1111;
        cyc();
        check("mid_no_deliver", int'(out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = 1'($urandom);
            in        = 4'($urandom);
            s         = 2'($urandom);
            out_ready = 4'($urandom);
            cyc();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
